mc_ctrl_gen2: RTL and testbench

- Second-generation multi-cycle controller FSM for the accumulator microprocessor.
- It decodes the 8-bit IR and drives the same datapath control strobes as the current controller.
- New features over the current controller:
  - data width is parametrised;
  - a memory wait-state handshake stalls every memory-access state;
  - JP/JPR use true positive/zero flag semantics;
  - illegal-opcode reporting;
  - a resumable HALT.
- Sits between the IR/accumulator and the PC, memory, register-file and ALU muxes.

---
 rtl/mc_ctrl_gen2.sv | 246 ++++++++++++++++++++++++
 tb/tb_mc_ctrl_gen2.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_gen2.sv
// mc_ctrl_gen2: multi-cycle controller FSM for the accumulator microprocessor.
// Decodes the 8-bit IR and drives the datapath control strobes, with optional
// memory wait states, illegal-opcode reporting and a resumable HALT.
//
// Handshake: a memory-access state completes on the first cycle mem_ready=1;
// while mem_ready=0 the state holds, every write/load strobe is held at 0 and
// the address/data selects stay driven so the memory sees a stable request.
// With WAIT_EN=0, mem_ready is ignored and every access completes at once.
module mc_ctrl_gen2 #(
    parameter int DATA_W  = 8,
    parameter bit WAIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        instr,
    input  logic [DATA_W-1:0] acc,
    input  logic              mem_ready,
    input  logic              resume,
    output logic              IRload,
    output logic              MRload,
    output logic [1:0]        JMPmux,
    output logic              PCload,
    output logic              MemInst,
    output logic              MemWr,
    output logic [1:0]        Asel,
    output logic              Aload,
    output logic              RFwr,
    output logic [2:0]        ALUsel,
    output logic [1:0]        Shiftsel,
    output logic              OutEn,
    output logic              halted,
    output logic              illegal,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMA   = 3'd3,
        S_LDM2   = 3'd4,
        S_STM2   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0] w_op;
    logic [3:0] w_lo;
    logic       w_ready;
    logic       w_zero;
    logic       w_pos;
    logic       w_is_jump;
    logic       w_abs;
    logic       w_take;
    logic       w_defined;
    logic       w_mem_access;
    logic       w_stall;

    assign w_op      = instr[7:4];
    assign w_lo      = instr[3:0];
    assign w_ready   = (WAIT_EN == 1'b0) || mem_ready;
    assign w_zero    = (acc == '0);
    assign w_pos     = !acc[DATA_W-1] && !w_zero;
    assign w_is_jump = (w_op >= 4'h6) && (w_op <= 4'h9);
    assign w_abs     = (w_lo == 4'h0);
    assign w_stall   = w_mem_access && !w_ready;
    assign o_dbg_state = r_state;

    // Jump condition, evaluated on the accumulator during EXEC.
    always_comb begin
        w_take = 1'b0;
        case (w_op)
            4'h6:    w_take = 1'b1;
            4'h7:    w_take = w_zero;
            4'h8:    w_take = !w_zero;
            4'h9:    w_take = w_pos;
            default: w_take = 1'b0;
        endcase
    end

    // Opcode legality: 0x0 row only has NOP, 0xE row ends at ROTR, 0xF row at HALT.
    always_comb begin
        w_defined = 1'b1;
        case (w_op)
            4'h0:    w_defined = (w_lo == 4'h0);
            4'hE:    w_defined = (w_lo <= 4'h5);
            4'hF:    w_defined = (w_lo <= 4'h2);
            default: w_defined = 1'b1;
        endcase
    end

    // States that talk to memory and therefore wait on mem_ready.
    always_comb begin
        w_mem_access = 1'b0;
        case (r_state)
            S_FETCH, S_MEMA, S_LDM2, S_STM2: w_mem_access = 1'b1;
            S_EXEC:  w_mem_access = (w_op == 4'h5) || (w_is_jump && w_abs);
            default: w_mem_access = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control-strobe decode.
    always_comb begin
        w_next   = r_state;
        IRload   = 1'b0;
        MRload   = 1'b0;
        JMPmux   = 2'b00;
        PCload   = 1'b0;
        MemInst  = 1'b0;
        MemWr    = 1'b0;
        Asel     = 2'b00;
        Aload    = 1'b0;
        RFwr     = 1'b0;
        ALUsel   = 3'b000;
        Shiftsel = 2'b00;
        OutEn    = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;

        case (r_state)
            S_FETCH: begin
                IRload = 1'b1;
                PCload = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (instr == 8'hF2) begin
                    w_next = S_HALT;
                end else if (w_op == 4'h3 || w_op == 4'h4) begin
                    w_next = S_MEMA;
                end else if (w_defined) begin
                    w_next = S_EXEC;
                end else begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_op)
                    4'h1: begin Asel = 2'b01; Aload = 1'b1; end
                    4'h2: RFwr = 1'b1;
                    4'h5: begin PCload = 1'b1; Asel = 2'b11; Aload = 1'b1; end
                    4'h6, 4'h7, 4'h8, 4'h9: begin
                        if (w_abs) begin
                            // Not-taken absolute jump still steps over its address byte.
                            PCload = 1'b1;
                            JMPmux = w_take ? 2'b01 : 2'b00;
                        end else if (w_take) begin
                            PCload = 1'b1;
                            JMPmux = instr[3] ? 2'b10 : 2'b11;
                        end
                    end
                    4'hA: begin Aload = 1'b1; ALUsel = 3'b001; end
                    4'hB: begin Aload = 1'b1; ALUsel = 3'b010; end
                    4'hC: begin Aload = 1'b1; ALUsel = 3'b100; end
                    4'hD: begin Aload = 1'b1; ALUsel = 3'b101; end
                    4'hE: begin
                        case (w_lo)
                            4'h0: begin Aload = 1'b1; ALUsel   = 3'b011; end
                            4'h1: begin Aload = 1'b1; ALUsel   = 3'b110; end
                            4'h2: begin Aload = 1'b1; ALUsel   = 3'b111; end
                            4'h3: begin Aload = 1'b1; Shiftsel = 2'b01;  end
                            4'h4: begin Aload = 1'b1; Shiftsel = 2'b10;  end
                            4'h5: begin Aload = 1'b1; Shiftsel = 2'b11;  end
                            default: ;
                        endcase
                    end
                    4'hF: begin
                        if (w_lo == 4'h0) begin
                            Asel  = 2'b10;
                            Aload = 1'b1;
                        end else if (w_lo == 4'h1) begin
                            OutEn = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEMA: begin
                MRload = 1'b1;
                PCload = 1'b1;
                w_next = (w_op == 4'h3) ? S_LDM2 : S_STM2;
            end
            S_LDM2: begin
                MemInst = 1'b1;
                Asel    = 2'b11;
                Aload   = 1'b1;
                w_next  = S_FETCH;
            end
            S_STM2: begin
                MemInst = 1'b1;
                MemWr   = 1'b1;
                w_next  = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    w_next = S_FETCH;
                end
            end
            default: w_next = S_FETCH;
        endcase

        // Stalled memory access: hold the state and every strobe, keep selects.
        if (w_stall) begin
            w_next = r_state;
            IRload = 1'b0;
            MRload = 1'b0;
            PCload = 1'b0;
            MemWr  = 1'b0;
            Aload  = 1'b0;
            RFwr   = 1'b0;
        end

        // Reset silences every output, including the status flags.
        if (!reset) begin
            IRload   = 1'b0;
            MRload   = 1'b0;
            JMPmux   = 2'b00;
            PCload   = 1'b0;
            MemInst  = 1'b0;
            MemWr    = 1'b0;
            Asel     = 2'b00;
            Aload    = 1'b0;
            RFwr     = 1'b0;
            ALUsel   = 3'b000;
            Shiftsel = 2'b00;
            OutEn    = 1'b0;
            halted   = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_gen2.sv
// Testbench for mc_ctrl_gen2: table-driven EXEC decode plus hand-written
// multi-cycle sequences, checked through an expected-output queue.
module tb_mc_ctrl_gen2;

    localparam int W = 19;

    // Packed control word: {IRload, MRload, JMPmux, PCload, MemInst, MemWr,
    //                       Asel, Aload, RFwr, ALUsel, Shiftsel, OutEn, halted, illegal}
    localparam logic [W-1:0] IRL = 19'h40000;
    localparam logic [W-1:0] MRL = 19'h20000;
    localparam logic [W-1:0] PCL = 19'h04000;
    localparam logic [W-1:0] MI  = 19'h02000;
    localparam logic [W-1:0] MW  = 19'h01000;
    localparam logic [W-1:0] AL  = 19'h00200;
    localparam logic [W-1:0] RFW = 19'h00100;
    localparam logic [W-1:0] OE  = 19'h00004;
    localparam logic [W-1:0] HLT = 19'h00002;
    localparam logic [W-1:0] ILL = 19'h00001;

    function automatic logic [W-1:0] jm(input logic [1:0] v);
        return W'(v) << 15;
    endfunction
    function automatic logic [W-1:0] as(input logic [1:0] v);
        return W'(v) << 10;
    endfunction
    function automatic logic [W-1:0] alu(input logic [2:0] v);
        return W'(v) << 5;
    endfunction
    function automatic logic [W-1:0] sh(input logic [1:0] v);
        return W'(v) << 3;
    endfunction

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        r_reset;
    logic [7:0]  r_instr;
    logic [15:0] r_acc;
    logic        r_mem_ready;
    logic        r_resume;

    // ---------------- DUT: 16-bit, wait states enabled ----------------
    logic       IRload, MRload, PCload, MemInst, MemWr, Aload, RFwr, OutEn, halted, illegal;
    logic [1:0] JMPmux, Asel, Shiftsel;
    logic [2:0] ALUsel, dbg_state;

    mc_ctrl_gen2 #(.DATA_W(16), .WAIT_EN(1'b1)) dut (
        .clk(clk), .reset(r_reset), .instr(r_instr), .acc(r_acc),
        .mem_ready(r_mem_ready), .resume(r_resume),
        .IRload(IRload), .MRload(MRload), .JMPmux(JMPmux), .PCload(PCload),
        .MemInst(MemInst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload), .RFwr(RFwr),
        .ALUsel(ALUsel), .Shiftsel(Shiftsel), .OutEn(OutEn), .halted(halted),
        .illegal(illegal), .o_dbg_state(dbg_state)
    );

    logic [W-1:0] act;
    assign act = {IRload, MRload, JMPmux, PCload, MemInst, MemWr, Asel, Aload, RFwr,
                  ALUsel, Shiftsel, OutEn, halted, illegal};

    // ---------------- DUT: 8-bit, wait states disabled ----------------
    logic       nw_IRload, nw_MRload, nw_PCload, nw_MemInst, nw_MemWr, nw_Aload;
    logic       nw_RFwr, nw_OutEn, nw_halted, nw_illegal;
    logic [1:0] nw_JMPmux, nw_Asel, nw_Shiftsel;
    logic [2:0] nw_ALUsel, nw_dbg_state;

    mc_ctrl_gen2 #(.DATA_W(8), .WAIT_EN(1'b0)) dut_nw (
        .clk(clk), .reset(r_reset), .instr(r_instr), .acc(r_acc[7:0]),
        .mem_ready(r_mem_ready), .resume(r_resume),
        .IRload(nw_IRload), .MRload(nw_MRload), .JMPmux(nw_JMPmux), .PCload(nw_PCload),
        .MemInst(nw_MemInst), .MemWr(nw_MemWr), .Asel(nw_Asel), .Aload(nw_Aload),
        .RFwr(nw_RFwr), .ALUsel(nw_ALUsel), .Shiftsel(nw_Shiftsel), .OutEn(nw_OutEn),
        .halted(nw_halted), .illegal(nw_illegal), .o_dbg_state(nw_dbg_state)
    );

    logic [W-1:0] nw_act;
    assign nw_act = {nw_IRload, nw_MRload, nw_JMPmux, nw_PCload, nw_MemInst, nw_MemWr,
                     nw_Asel, nw_Aload, nw_RFwr, nw_ALUsel, nw_Shiftsel, nw_OutEn,
                     nw_halted, nw_illegal};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic compare(input logic [W-1:0] got, input string nm);
        logic [W-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected entry, got %05h", nm, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got %05h expected %05h", nm, got, e);
            end
        end
    endtask

    // Drive one cycle of inputs, record expectation, sample mid-cycle, advance.
    task automatic apply(input logic [7:0] ins, input logic [15:0] a, input logic mr,
                         input logic rs, input logic rst, input logic [W-1:0] e,
                         input string nm);
        r_instr = ins; r_acc = a; r_mem_ready = mr; r_resume = rs; r_reset = rst;
        exp_q.push_back(e);
        #2;
        compare(act, nm);
        @(posedge clk); #1;
    endtask

    // Same, also checking the no-wait instance.
    task automatic apply2(input logic [7:0] ins, input logic mr, input logic [W-1:0] e,
                          input logic [W-1:0] e_nw, input string nm);
        r_instr = ins; r_acc = 16'h0; r_mem_ready = mr; r_resume = 1'b0; r_reset = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(e_nw);
        #2;
        compare(act, nm);
        compare(nw_act, {nm, " nowait"});
        @(posedge clk); #1;
    endtask

    // FETCH, DECODE, EXEC with memory ready; checks all three cycles.
    task automatic run_exec(input logic [7:0] ins, input logic [15:0] a,
                            input logic [W-1:0] e, input string nm);
        apply(ins, a, 1'b1, 1'b0, 1'b1, IRL | PCL, {nm, " fetch"});
        apply(ins, a, 1'b1, 1'b0, 1'b1, '0,        {nm, " decode"});
        apply(ins, a, 1'b1, 1'b0, 1'b1, e,         {nm, " exec"});
    endtask

    typedef struct {
        logic [7:0]   ins;
        logic [15:0]  acc;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] bad_ops[$];

    initial begin
        // EXEC-cycle decode table
        tbl.push_back(vec_t'{8'h00, 16'h0000, '0});
        tbl.push_back(vec_t'{8'h13, 16'h0000, as(2'b01) | AL});
        tbl.push_back(vec_t'{8'h25, 16'h0000, RFW});
        tbl.push_back(vec_t'{8'h50, 16'h0000, PCL | as(2'b11) | AL});
        tbl.push_back(vec_t'{8'hA0, 16'h0000, AL | alu(3'b001)});
        tbl.push_back(vec_t'{8'hB0, 16'h0000, AL | alu(3'b010)});
        tbl.push_back(vec_t'{8'hC0, 16'h0000, AL | alu(3'b100)});
        tbl.push_back(vec_t'{8'hD0, 16'h0000, AL | alu(3'b101)});
        tbl.push_back(vec_t'{8'hE0, 16'h0000, AL | alu(3'b011)});
        tbl.push_back(vec_t'{8'hE1, 16'h0000, AL | alu(3'b110)});
        tbl.push_back(vec_t'{8'hE2, 16'h0000, AL | alu(3'b111)});
        tbl.push_back(vec_t'{8'hE3, 16'h0000, AL | sh(2'b01)});
        tbl.push_back(vec_t'{8'hE4, 16'h0000, AL | sh(2'b10)});
        tbl.push_back(vec_t'{8'hE5, 16'h0000, AL | sh(2'b11)});
        tbl.push_back(vec_t'{8'hF0, 16'h0000, as(2'b10) | AL});
        tbl.push_back(vec_t'{8'hF1, 16'h0000, OE});
        tbl.push_back(vec_t'{8'h60, 16'h0000, PCL | jm(2'b01)});
        tbl.push_back(vec_t'{8'h6F, 16'h0005, PCL | jm(2'b10)});
        tbl.push_back(vec_t'{8'h63, 16'h0000, PCL | jm(2'b11)});
        tbl.push_back(vec_t'{8'h70, 16'h0000, PCL | jm(2'b01)});
        tbl.push_back(vec_t'{8'h70, 16'h0100, PCL});
        tbl.push_back(vec_t'{8'h7A, 16'h0000, PCL | jm(2'b10)});
        tbl.push_back(vec_t'{8'h7A, 16'h0003, '0});
        tbl.push_back(vec_t'{8'h80, 16'h0000, PCL});
        tbl.push_back(vec_t'{8'h80, 16'h8000, PCL | jm(2'b01)});
        tbl.push_back(vec_t'{8'h85, 16'h0001, PCL | jm(2'b11)});
        tbl.push_back(vec_t'{8'h85, 16'h0000, '0});
        tbl.push_back(vec_t'{8'h90, 16'h8000, PCL});
        tbl.push_back(vec_t'{8'h90, 16'h0005, PCL | jm(2'b01)});
        tbl.push_back(vec_t'{8'h90, 16'h0000, PCL});
        tbl.push_back(vec_t'{8'h9C, 16'h0000, '0});
        tbl.push_back(vec_t'{8'h9C, 16'h7FFF, PCL | jm(2'b10)});
        tbl.push_back(vec_t'{8'h94, 16'hFFFF, '0});
        bad_ops = '{8'h01, 8'h0F, 8'hE6, 8'hEF, 8'hF3, 8'hF7, 8'hFF};

        r_reset = 1'b0; r_instr = 8'h00; r_acc = 16'h0; r_mem_ready = 1'b1; r_resume = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: everything low
        apply(8'h00, 16'h0, 1'b1, 1'b0, 1'b0, '0, "reset outputs");

        // Wait-state disable: no-wait instance ignores mem_ready
        apply2(8'hC0, 1'b0, '0, IRL | PCL, "fetch mr0");
        apply2(8'hC0, 1'b0, '0, '0,        "fetch mr0 2");
        apply(8'h00, 16'h0, 1'b1, 1'b0, 1'b0, '0, "reset again");

        // FETCH stalled for 3 cycles, then ADD
        for (int i = 0; i < 3; i++)
            apply(8'hC0, 16'h0, 1'b0, 1'b0, 1'b1, '0, "fetch stall");
        apply(8'hC0, 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL, "fetch release");
        apply(8'hC0, 16'h0, 1'b1, 1'b0, 1'b1, '0, "add decode");
        apply(8'hC0, 16'h0, 1'b1, 1'b0, 1'b1, AL | alu(3'b100), "add exec");

        // LDM interrupted by reset in LDM2, then a clean LDM
        apply(8'h30, 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL, "ldm fetch");
        apply(8'h30, 16'h0, 1'b1, 1'b0, 1'b1, '0, "ldm decode");
        apply(8'h30, 16'h0, 1'b0, 1'b0, 1'b1, '0, "mema stall");
        apply(8'h30, 16'h0, 1'b1, 1'b0, 1'b1, MRL | PCL, "mema");
        apply(8'h30, 16'h0, 1'b1, 1'b0, 1'b0, '0, "reset in ldm2 1");
        apply(8'h30, 16'h0, 1'b1, 1'b0, 1'b0, '0, "reset in ldm2 2");
        apply(8'h30, 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL, "post reset fetch");
        apply(8'h30, 16'h0, 1'b1, 1'b0, 1'b1, '0, "ldm decode 2");
        apply(8'h30, 16'h0, 1'b1, 1'b0, 1'b1, MRL | PCL, "mema 2");
        apply(8'h30, 16'h0, 1'b1, 1'b0, 1'b1, MI | as(2'b11) | AL, "ldm2");

        // STM with a stall in STM2
        apply(8'h41, 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL, "stm fetch");
        apply(8'h41, 16'h0, 1'b1, 1'b0, 1'b1, '0, "stm decode");
        apply(8'h41, 16'h0, 1'b1, 1'b0, 1'b1, MRL | PCL, "stm mema");
        apply(8'h41, 16'h0, 1'b0, 1'b0, 1'b1, MI, "stm2 stall");
        apply(8'h41, 16'h0, 1'b1, 1'b0, 1'b1, MI | MW, "stm2");

        // EXEC stalls: LDI and absolute jump hold; relative jump and ALU do not
        apply(8'h55, 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL, "ldi fetch");
        apply(8'h55, 16'h0, 1'b1, 1'b0, 1'b1, '0, "ldi decode");
        apply(8'h55, 16'h0, 1'b0, 1'b0, 1'b1, as(2'b11), "ldi stall");
        apply(8'h55, 16'h0, 1'b1, 1'b0, 1'b1, PCL | as(2'b11) | AL, "ldi exec");
        apply(8'h60, 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL, "jmp fetch");
        apply(8'h60, 16'h0, 1'b1, 1'b0, 1'b1, '0, "jmp decode");
        apply(8'h60, 16'h0, 1'b0, 1'b0, 1'b1, jm(2'b01), "jmp stall");
        apply(8'h60, 16'h0, 1'b1, 1'b0, 1'b1, PCL | jm(2'b01), "jmp exec");
        apply(8'h63, 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL, "jmpr fetch");
        apply(8'h63, 16'h0, 1'b1, 1'b0, 1'b1, '0, "jmpr decode");
        apply(8'h63, 16'h0, 1'b0, 1'b0, 1'b1, PCL | jm(2'b11), "jmpr mr0");
        apply(8'hC0, 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL, "add2 fetch");
        apply(8'hC0, 16'h0, 1'b1, 1'b0, 1'b1, '0, "add2 decode");
        apply(8'hC0, 16'h0, 1'b0, 1'b0, 1'b1, AL | alu(3'b100), "add2 mr0");

        // Illegal opcodes: one-cycle pulse in DECODE, back to FETCH
        foreach (bad_ops[k]) begin
            apply(bad_ops[k], 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL,
                  $sformatf("ill %02h fetch", bad_ops[k]));
            apply(bad_ops[k], 16'h0, 1'b1, 1'b0, 1'b1, ILL,
                  $sformatf("ill %02h decode", bad_ops[k]));
        end

        // HALT, resume, resume ignored elsewhere, reset beats resume
        apply(8'hF2, 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL, "halt fetch");
        apply(8'hF2, 16'h0, 1'b1, 1'b0, 1'b1, '0, "halt decode");
        apply(8'hF2, 16'h0, 1'b1, 1'b0, 1'b1, HLT, "halt 1");
        apply(8'hF2, 16'h0, 1'b0, 1'b0, 1'b1, HLT, "halt 2");
        apply(8'hF2, 16'h0, 1'b1, 1'b1, 1'b1, HLT, "halt resume");
        apply(8'hC0, 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL, "resume fetch");
        apply(8'hC0, 16'h0, 1'b1, 1'b1, 1'b1, '0, "decode w resume");
        apply(8'hC0, 16'h0, 1'b1, 1'b1, 1'b1, AL | alu(3'b100), "exec w resume");
        apply(8'hF2, 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL, "halt2 fetch");
        apply(8'hF2, 16'h0, 1'b1, 1'b0, 1'b1, '0, "halt2 decode");
        apply(8'hF2, 16'h0, 1'b1, 1'b0, 1'b1, HLT, "halt2");
        apply(8'hF2, 16'h0, 1'b1, 1'b1, 1'b0, '0, "reset beats resume");
        apply(8'h00, 16'h0, 1'b1, 1'b0, 1'b1, IRL | PCL, "post halt reset");
        apply(8'h00, 16'h0, 1'b1, 1'b0, 1'b1, '0, "nop decode");
        apply(8'h00, 16'h0, 1'b1, 1'b0, 1'b1, '0, "nop exec");

        // Table-driven EXEC decode
        for (int i = 0; i < tbl.size(); i++)
            run_exec(tbl[i].ins, tbl[i].acc, tbl[i].exp,
                     $sformatf("tbl %02h/%04h", tbl[i].ins, tbl[i].acc));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
